corefifo_rd_ptr_ctrl: RTL and testbench
=======================================

# corefifo_rd_ptr_ctrl

Read-domain pointer and flag controller for the dual-clock COREFIFO. It sits directly downstream of the N-stage pointer synchronizer and consumes the synchronized gray-coded write pointer. It maintains the read pointer and produces the FIFO memory read address/enable, plus the empty, almost-empty, level and underflow indications. It also drives a registered gray read pointer back toward the write-domain synchronizer.

## Interface
- ADDRWIDTH, 3: memory address width; FIFO depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits.
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH.

- clk  in  1  read-domain clock; all logic on rising edge.
- srst  in  1  reset, synchronous, active-high.
- re  in  1  read request.
- wptr_sync_gray  in  ADDRWIDTH+1  gray write pointer, already synchronized into clk domain.
- rptr_gray  out  ADDRWIDTH+1  registered gray read pointer, to write-domain synchronizer.
- raddr  out  ADDRWIDTH  memory read address = rptr_bin[ADDRWIDTH-1:0].
- ren_mem  out  1  memory read enable = re & ~empty (combinational from registered empty).
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered.
- rd_count  out  ADDRWIDTH+1  registered level, 0..2^ADDRWIDTH.
- data_valid  out  1  memory data valid; one cycle after an accepted read.
- underflow  out  1  one-cycle pulse on read attempt while empty.

## Operation
- Accepted read: rd_acc = re & ~empty. Reads while empty are ignored: pointer holds, underflow=1 next cycle.
- wbin = gray-to-binary(wptr_sync_gray): wbin[i] = XOR of gray[ADDRWIDTH:i].
- rbin_next = rptr_bin + rd_acc, modulo 2^(ADDRWIDTH+1) (natural wrap, no saturation).
- rptr_gray <= rbin_next ^ (rbin_next >> 1), registered from the next value; single-bit change per increment, glitch-free.
- empty <= (rbin_next == wbin).
- rd_count <= (wbin - rbin_next) mod 2^(ADDRWIDTH+1). Value 2^ADDRWIDTH means full (MSBs differ, lower bits equal).
- almost_empty <= (rd_count_next <= AE_THRESH).
- data_valid <= rd_acc.
- Reset values (srst=1): rptr_bin=0, rptr_gray=0, raddr=0, empty=1, almost_empty=1, rd_count=0, data_valid=0, underflow=0. ren_mem=0 follows from empty=1.
- srst dominates re. A read accepted in the reset cycle is discarded: no pointer advance, and data_valid=0 on the next cycle.
- Simultaneous write-pointer advance and read: both are applied in the same update. Level = new wbin − new rbin.
- Flags are pessimistic. empty/rd_count reflect writes only after synchronizer latency plus 1 cycle; they never report data that has not yet been written.
- Behaviour for multi-step jumps in wptr_sync_gray (a protocol violation) is undefined, but the arithmetic must remain modulo-correct.

## Timing
- re -> ren_mem/raddr: same cycle (raddr is the current pointer).
- re accepted at edge k -> data_valid=1 and memory data at edge k+1. Pointer, rptr_gray, empty, rd_count and almost_empty update at edge k+1.
- wptr_sync_gray change -> empty/rd_count/almost_empty update at the next edge.
- Back-to-back reads are sustained at 1 per cycle until empty.
- A read of the last word at edge k -> empty=1 at k+1. A re at k+1 is then rejected.

## Structure
- Shared package corefifo_pkg: PTRW = ADDRWIDTH+1 width rule, functions bin2gray and gray2bin (parameterized width).
- One natural sub-module: corefifo_gray2bin (combinational XOR-prefix converter), reused by the write-side controller.
- All flags come directly from flops; no combinational path from wptr_sync_gray to outputs.

## Test plan
- Reset: hold srst 2 cycles with re=1 and wptr_sync_gray=0011 -> empty=1, almost_empty=1, rd_count=0, rptr_gray=0000, data_valid=0, underflow=0.
- Fill/drain: ADDRWIDTH=3, AE_THRESH=1, wptr_sync_gray 0000 -> 0011 (bin 2) -> next edge empty=0, rd_count=2, almost_empty=0. Then re=1 for 2 cycles -> raddr 0,1; data_valid 1,1; rd_count 1 then 0; almost_empty=1 after the first read; empty=1 after the second.
- Underflow: empty=1, re=1 for one cycle -> underflow=1 for exactly one cycle; rptr_gray unchanged; data_valid=0; ren_mem=0.
- Full and wrap: wptr_sync_gray=1100 (bin 8) with rptr=0 -> rd_count=8. Read 8 -> rptr_gray=1100, empty=1. Advance write to bin 0 (gray 0000) and read 8 more -> rptr_gray=0000 after the wrap; rd_count never exceeds 8.
- Simultaneous: rd_count=1, re=1 while wptr advances bin1->bin2 in the same cycle -> rd_count stays 1, empty stays 0, raddr increments.
- Reset mid-stream: rd_count=5, re=1 and srst=1 in the same cycle -> next cycle rptr=0, rd_count=0, empty=1, data_valid=0.

Source files
------------

// File: rtl/corefifo_pkg.sv
// Shared helpers for the COREFIFO pointer controllers: pointer width rule and
// gray/binary conversion on a wide container (callers cast to their width).
package corefifo_pkg;

    localparam int CONV_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extension leaves the low bits' XOR-prefix unchanged, so any width fits.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < CONV_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/corefifo_rd_ptr_ctrl_if.sv
// Read-side bundle: read request and synchronized write pointer in, memory
// control, gray read pointer and status flags out.
interface corefifo_rd_ptr_ctrl_if
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH = 3
);
    localparam int PTRW = ptr_width(ADDRWIDTH);

    logic                 re;
    logic [PTRW-1:0]      wptr_sync_gray;
    logic [PTRW-1:0]      rptr_gray;
    logic [ADDRWIDTH-1:0] raddr;
    logic                 ren_mem;
    logic                 empty;
    logic                 almost_empty;
    logic [PTRW-1:0]      rd_count;
    logic                 data_valid;
    logic                 underflow;

    modport master (
        output re, wptr_sync_gray,
        input  rptr_gray, raddr, ren_mem, empty, almost_empty, rd_count,
               data_valid, underflow
    );

    modport slave (
        input  re, wptr_sync_gray,
        output rptr_gray, raddr, ren_mem, empty, almost_empty, rd_count,
               data_valid, underflow
    );

endinterface

// File: rtl/corefifo_gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of the
// gray bits at and above its position.
module corefifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign bin_o[gi] = ^gray_i[W-1:gi];
    end

endmodule

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read-domain pointer/flag controller for the dual-clock COREFIFO. All flags
// are flops fed from the post-read pointer against the synchronized write pointer.
module corefifo_rd_ptr_ctrl
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input logic                  clk,
    input logic                  srst,
    corefifo_rd_ptr_ctrl_if.slave bus
);

    localparam int PTRW = ptr_width(ADDRWIDTH);

    logic [PTRW-1:0] wbin;
    logic            rd_acc;

    logic [PTRW-1:0] rbin_q, rbin_d;
    logic [PTRW-1:0] rgray_q, rgray_d;
    logic [PTRW-1:0] count_q, count_d;
    logic            empty_q, empty_d;
    logic            ae_q, ae_d;
    logic            dv_q, dv_d;
    logic            uf_q, uf_d;

    corefifo_gray2bin #(.W(PTRW)) u_wptr_g2b (
        .gray_i (bus.wptr_sync_gray),
        .bin_o  (wbin)
    );

    always_comb begin
        rd_acc  = bus.re & ~empty_q;
        rbin_d  = rbin_q + PTRW'(rd_acc);
        rgray_d = PTRW'(bin2gray(CONV_W'(rbin_d)));
        // Level wraps modulo 2^PTRW, so a full FIFO reads back as 2^ADDRWIDTH.
        count_d = wbin - rbin_d;
        empty_d = (rbin_d == wbin);
        ae_d    = (CONV_W'(count_d) <= CONV_W'(AE_THRESH));
        dv_d    = rd_acc;
        uf_d    = bus.re & empty_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            dv_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            count_q <= count_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            dv_q    <= dv_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.rptr_gray    = rgray_q;
    assign bus.raddr        = rbin_q[ADDRWIDTH-1:0];
    assign bus.ren_mem      = rd_acc;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_count     = count_q;
    assign bus.data_valid   = dv_q;
    assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Directed bench for corefifo_rd_ptr_ctrl: an integer-arithmetic model checked
// every cycle, plus literal expectations at the scenario checkpoints.
module tb_corefifo_rd_ptr_ctrl;

    localparam int AW    = 3;
    localparam int AE    = 1;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 2 * DEPTH;

    logic clk;
    logic srst;

    corefifo_rd_ptr_ctrl_if #(.ADDRWIDTH(AW)) bus ();

    corefifo_rd_ptr_ctrl #(.ADDRWIDTH(AW), .AE_THRESH(AE)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    // Model: read pointer and level as plain integers modulo 2*DEPTH.
    int m_r = 0;
    int m_cnt = 0;
    bit m_empty = 1, m_ae = 1, m_dv = 0, m_uf = 0, m_valid = 0;

    always @(posedge clk) begin
        int w;
        bit acc;
        cyc++;
        if (srst) begin
            m_r = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_dv = 0; m_uf = 0;
        end else begin
            w       = from_gray(bus.wptr_sync_gray);
            acc     = bus.re && !m_empty;
            m_uf    = bus.re && m_empty;
            m_dv    = acc;
            m_r     = (m_r + int'(acc)) % MOD;
            m_cnt   = ((w - m_r) % MOD + MOD) % MOD;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= AE);
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_empty",  int'(bus.empty),        int'(m_empty));
            chk("m_ae",     int'(bus.almost_empty), int'(m_ae));
            chk("m_count",  int'(bus.rd_count),     m_cnt);
            chk("m_gray",   int'(bus.rptr_gray),    int'(to_gray(m_r)));
            chk("m_raddr",  int'(bus.raddr),        m_r % DEPTH);
            chk("m_dv",     int'(bus.data_valid),   int'(m_dv));
            chk("m_uf",     int'(bus.underflow),    int'(m_uf));
            chk("m_ren",    int'(bus.ren_mem),      int'(bus.re && !m_empty));
            chk("m_cnt_le", int'(bus.rd_count <= 4'(DEPTH)), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("cyc=%0d srst=%0b re=%0b wg=%b | rg=%b ra=%0d ren=%0b e=%0b ae=%0b cnt=%0d dv=%0b uf=%0b",
                 cyc, srst, bus.re, bus.wptr_sync_gray, bus.rptr_gray, bus.raddr,
                 bus.ren_mem, bus.empty, bus.almost_empty, bus.rd_count,
                 bus.data_valid, bus.underflow);
    endtask

    initial begin
        srst = 1'b1;
        bus.re = 1'b1;
        bus.wptr_sync_gray = 4'b0011;
        step();
        step();
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_ae",    int'(bus.almost_empty), 1);
        chk("rst_cnt",   int'(bus.rd_count), 0);
        chk("rst_gray",  int'(bus.rptr_gray), 0);
        chk("rst_dv",    int'(bus.data_valid), 0);
        chk("rst_uf",    int'(bus.underflow), 0);
        chk("rst_ren",   int'(bus.ren_mem), 0);

        // Fill to 2, then drain
        srst = 1'b0; bus.re = 1'b0; bus.wptr_sync_gray = 4'b0000;
        step();
        bus.wptr_sync_gray = 4'b0011;
        step();
        chk("fill_empty", int'(bus.empty), 0);
        chk("fill_cnt",   int'(bus.rd_count), 2);
        chk("fill_ae",    int'(bus.almost_empty), 0);
        bus.re = 1'b1;
        #1;
        chk("rd0_raddr", int'(bus.raddr), 0);
        chk("rd0_ren",   int'(bus.ren_mem), 1);
        step();
        chk("rd1_dv",    int'(bus.data_valid), 1);
        chk("rd1_cnt",   int'(bus.rd_count), 1);
        chk("rd1_ae",    int'(bus.almost_empty), 1);
        chk("rd1_raddr", int'(bus.raddr), 1);
        step();
        chk("rd2_dv",    int'(bus.data_valid), 1);
        chk("rd2_cnt",   int'(bus.rd_count), 0);
        chk("rd2_empty", int'(bus.empty), 1);
        chk("uf_ren",    int'(bus.ren_mem), 0);
        step();
        chk("uf_pulse",  int'(bus.underflow), 1);
        chk("uf_dv",     int'(bus.data_valid), 0);
        chk("uf_gray",   int'(bus.rptr_gray), 4'b0011);
        bus.re = 1'b0;
        step();
        chk("uf_clear",  int'(bus.underflow), 0);

        // Full and wrap
        srst = 1'b1;
        step();
        srst = 1'b0; bus.wptr_sync_gray = 4'b1100;
        step();
        chk("full_cnt",   int'(bus.rd_count), 8);
        chk("full_empty", int'(bus.empty), 0);
        bus.re = 1'b1;
        repeat (8) step();
        chk("half_gray",  int'(bus.rptr_gray), 4'b1100);
        chk("half_empty", int'(bus.empty), 1);
        bus.re = 1'b0; bus.wptr_sync_gray = 4'b0000;
        step();
        chk("wrap_cnt", int'(bus.rd_count), 8);
        bus.re = 1'b1;
        repeat (8) step();
        chk("wrap_gray",  int'(bus.rptr_gray), 4'b0000);
        chk("wrap_empty", int'(bus.empty), 1);

        // Simultaneous write advance and read
        bus.re = 1'b0; bus.wptr_sync_gray = to_gray(1);
        step();
        chk("sim_pre_cnt", int'(bus.rd_count), 1);
        bus.re = 1'b1; bus.wptr_sync_gray = to_gray(2);
        step();
        chk("sim_cnt",   int'(bus.rd_count), 1);
        chk("sim_empty", int'(bus.empty), 0);
        chk("sim_raddr", int'(bus.raddr), 1);

        // Reset mid-stream
        bus.re = 1'b0; bus.wptr_sync_gray = to_gray(6);
        step();
        chk("mid_cnt", int'(bus.rd_count), 5);
        bus.re = 1'b1; srst = 1'b1;
        step();
        chk("mid_gray",  int'(bus.rptr_gray), 0);
        chk("mid_raddr", int'(bus.raddr), 0);
        chk("mid_cnt0",  int'(bus.rd_count), 0);
        chk("mid_empty", int'(bus.empty), 1);
        chk("mid_dv",    int'(bus.data_valid), 0);
        srst = 1'b0; bus.re = 1'b0;
        step();
        chk("post_cnt", int'(bus.rd_count), 6);

        // Mixed single-step writes and reads, checked by the model
        for (int i = 0; i < 24; i++) begin
            int w;
            w = from_gray(bus.wptr_sync_gray);
            if ((i % 3) != 2 && m_cnt < DEPTH - 1)
                bus.wptr_sync_gray = to_gray((w + 1) % MOD);
            bus.re = (i % 2 == 1) || (i > 16);
            step();
        end
        bus.re = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
